// File: rtl/m_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// m_mem_bus_arbiter
//
// Shares a single memory port between three requesters: the page-table
// walker (PTW), the core data bus (DBUS) and the instruction fetch unit
// (IBUS). One transaction is in flight at a time. The winner of a
// round-robin arbitration has its request captured into registers and
// driven onto the memory port. Read data and a bus error flag come back
// alongside a one-cycle ack to the winner. If memory never acks, a timeout
// completes the transaction with an error.
//
// Transaction flow: IDLE (arbitrate) -> BUSY (memory request held) ->
// DONE (ack pulse) -> IDLE.
//
// Ports
//   clk_in, rst_in               clock, synchronous active-low reset
//   pw_req_i, pw_addr_i          PTW read request and address
//   db_ld_req_i, db_st_req_i     DBUS load / store requests
//   db_addr_i, db_wdata_i,
//   db_byte_en_i                 DBUS address, store data, byte enables
//   ib_req_i, ib_addr_i          IBUS fetch request and address
//   pw_ack_o, db_ack_o, ib_ack_o one-cycle completion pulse per requester
//   rdata_o, err_o               read data and bus error, valid with an ack
//   grant_o                      current owner: 0=PTW 1=DBUS 2=IBUS 3=none
//   mem_addr_o, mem_wdata_o,
//   mem_byte_en_o                memory address, write data, byte enables
//   mem_ld_req_o, mem_st_req_o   memory read / write request
//   mem_rdata_i, mem_ack_i       memory read data and completion
//
// Every output comes straight from a register, so nothing on the memory
// port depends combinationally on the requester inputs.
// ---------------------------------------------------------------------------
module m_mem_bus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_in,
  input  logic              rst_in,

  input  logic              pw_req_i,
  input  logic [AW-1:0]     pw_addr_i,

  input  logic              db_ld_req_i,
  input  logic              db_st_req_i,
  input  logic [AW-1:0]     db_addr_i,
  input  logic [DW-1:0]     db_wdata_i,
  input  logic [DW/8-1:0]   db_byte_en_i,

  input  logic              ib_req_i,
  input  logic [AW-1:0]     ib_addr_i,

  output logic              pw_ack_o,
  output logic              db_ack_o,
  output logic              ib_ack_o,
  output logic [DW-1:0]     rdata_o,
  output logic              err_o,
  output logic [1:0]        grant_o,

  output logic [AW-1:0]     mem_addr_o,
  output logic [DW-1:0]     mem_wdata_o,
  output logic [DW/8-1:0]   mem_byte_en_o,
  output logic              mem_ld_req_o,
  output logic              mem_st_req_o,
  input  logic [DW-1:0]     mem_rdata_i,
  input  logic              mem_ack_i
);

  localparam int BW = DW / 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] GNT_PTW  = 2'd0;
  localparam logic [1:0] GNT_DB   = 2'd1;
  localparam logic [1:0] GNT_IB   = 2'd2;
  localparam logic [1:0] GNT_NONE = 2'd3;

  // The counter only has to reach TIMEOUT-1: the BUSY cycle in which it
  // sits at that value is the last one, so BUSY lasts exactly TIMEOUT cycles.
  localparam int              CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit              TO_EN    = (TIMEOUT > 0);

  logic [1:0]      r_state;
  logic [1:0]      r_last;
  logic [1:0]      r_grant;
  logic [CW-1:0]   r_cnt;

  logic [AW-1:0]   r_mem_addr;
  logic [DW-1:0]   r_mem_wdata;
  logic [BW-1:0]   r_mem_be;
  logic            r_mem_ld;
  logic            r_mem_st;

  logic            r_pw_ack;
  logic            r_db_ack;
  logic            r_ib_ack;
  logic [DW-1:0]   r_rdata;
  logic            r_err;

  logic            w_db_req;
  logic [1:0]      w_winner;
  logic            w_valid;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_wdata;
  logic [BW-1:0]   w_sel_be;
  logic            w_sel_st;
  logic            w_busy_ok;
  logic            w_busy_to;

  assign w_db_req = db_ld_req_i | db_st_req_i;

  // Round-robin pick: search starts just after the previous winner in the
  // ring PTW -> DBUS -> IBUS -> PTW, so the previous winner is the last one
  // considered. Reset leaves r_last at IBUS, which puts PTW first.
  always_comb begin
    w_winner = GNT_NONE;
    case (r_last)
      GNT_PTW: begin
        if (w_db_req)      w_winner = GNT_DB;
        else if (ib_req_i) w_winner = GNT_IB;
        else if (pw_req_i) w_winner = GNT_PTW;
      end
      GNT_DB: begin
        if (ib_req_i)      w_winner = GNT_IB;
        else if (pw_req_i) w_winner = GNT_PTW;
        else if (w_db_req) w_winner = GNT_DB;
      end
      default: begin
        if (pw_req_i)      w_winner = GNT_PTW;
        else if (w_db_req) w_winner = GNT_DB;
        else if (ib_req_i) w_winner = GNT_IB;
      end
    endcase
  end

  assign w_valid = (w_winner != GNT_NONE);

  // Request fields of the winner. Reads always present all-ones byte
  // enables and zero write data. A DBUS request with load and store both
  // set is taken as a store.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    w_sel_be    = '0;
    w_sel_st    = 1'b0;
    case (w_winner)
      GNT_PTW: begin
        w_sel_addr = pw_addr_i;
        w_sel_be   = '1;
      end
      GNT_DB: begin
        w_sel_addr = db_addr_i;
        w_sel_st   = db_st_req_i;
        if (db_st_req_i) begin
          w_sel_wdata = db_wdata_i;
          w_sel_be    = db_byte_en_i;
        end else begin
          w_sel_be    = '1;
        end
      end
      GNT_IB: begin
        w_sel_addr = ib_addr_i;
        w_sel_be   = '1;
      end
      default: begin
        w_sel_addr = '0;
      end
    endcase
  end

  // A BUSY cycle ends either with a memory ack or, when the timeout is
  // enabled, after the counter has spent its last cycle. An ack arriving in
  // that same last cycle still counts as a normal completion.
  assign w_busy_ok = mem_ack_i;
  assign w_busy_to = TO_EN && !mem_ack_i && (r_cnt == CNT_LAST);

  // Main FSM and all output registers. Reset abandons any transaction in
  // flight without an ack and drops the memory request on the next cycle.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state     <= ST_IDLE;
      r_last      <= GNT_IB;
      r_grant     <= GNT_NONE;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_mem_ld    <= 1'b0;
      r_mem_st    <= 1'b0;
      r_pw_ack    <= 1'b0;
      r_db_ack    <= 1'b0;
      r_ib_ack    <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_be    <= w_sel_be;
            r_mem_ld    <= !w_sel_st;
            r_mem_st    <= w_sel_st;
            r_last      <= w_winner;
            r_grant     <= w_winner;
            r_cnt       <= '0;
            r_state     <= ST_BUSY;
          end
        end

        ST_BUSY: begin
          if (w_busy_ok || w_busy_to) begin
            r_rdata  <= w_busy_ok ? mem_rdata_i : '0;
            r_err    <= !w_busy_ok;
            r_mem_ld <= 1'b0;
            r_mem_st <= 1'b0;
            r_pw_ack <= (r_grant == GNT_PTW);
            r_db_ack <= (r_grant == GNT_DB);
            r_ib_ack <= (r_grant == GNT_IB);
            r_state  <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        ST_DONE: begin
          r_pw_ack <= 1'b0;
          r_db_ack <= 1'b0;
          r_ib_ack <= 1'b0;
          r_grant  <= GNT_NONE;
          r_state  <= ST_IDLE;
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign pw_ack_o      = r_pw_ack;
  assign db_ack_o      = r_db_ack;
  assign ib_ack_o      = r_ib_ack;
  assign rdata_o       = r_rdata;
  assign err_o         = r_err;
  assign grant_o       = r_grant;
  assign mem_addr_o    = r_mem_addr;
  assign mem_wdata_o   = r_mem_wdata;
  assign mem_byte_en_o = r_mem_be;
  assign mem_ld_req_o  = r_mem_ld;
  assign mem_st_req_o  = r_mem_st;

endmodule
